// File: rtl/ex_hazard_controller_pkg.sv
//------------------------------------------------------------------------------
// Module   : hazard_pkg
// Brief    : Shared types and constants for the execute-stage hazard controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } hz_state_t;

    localparam int ZERO_REG = 31;

    // Bit positions inside the {carry, zero, overflow, negative} flag vector
    localparam int FLAG_C = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

endpackage

`default_nettype wire

// File: rtl/ex_hazard_controller_if.sv
//------------------------------------------------------------------------------
// Module   : ex_hazard_controller_if
// Brief    : Pipeline-side bundle seen by the execute-stage hazard controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ex_hazard_controller_if #(
    parameter int REG_ADDR_W = 5,
    parameter int FLAG_W     = 4
);
    logic [REG_ADDR_W-1:0] id_rn;
    logic [REG_ADDR_W-1:0] id_rm;
    logic                  id_uses_rn;
    logic                  id_uses_rm;
    logic                  id_is_cbz;
    logic                  id_is_blt;
    logic                  id_flush;
    logic [REG_ADDR_W-1:0] ex_rn;
    logic [REG_ADDR_W-1:0] ex_rm;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_reg_write;
    logic                  ex_mem_read;
    logic                  ex_set_flags;
    logic [FLAG_W-1:0]     alu_flags;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  mem_reg_write;
    logic                  mem_mem_read;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic                  wb_reg_write;
    logic [1:0]            fwd_a;
    logic [1:0]            fwd_b;
    logic [1:0]            fwd_cbz;
    logic                  stall;
    logic                  idex_bubble;
    logic [FLAG_W-1:0]     flags;
    logic                  blt_taken;

    modport master (
        output id_rn, id_rm, id_uses_rn, id_uses_rm, id_is_cbz, id_is_blt, id_flush,
        output ex_rn, ex_rm, ex_rd, ex_reg_write, ex_mem_read, ex_set_flags, alu_flags,
        output mem_rd, mem_reg_write, mem_mem_read, wb_rd, wb_reg_write,
        input  fwd_a, fwd_b, fwd_cbz, stall, idex_bubble, flags, blt_taken
    );

    modport slave (
        input  id_rn, id_rm, id_uses_rn, id_uses_rm, id_is_cbz, id_is_blt, id_flush,
        input  ex_rn, ex_rm, ex_rd, ex_reg_write, ex_mem_read, ex_set_flags, alu_flags,
        input  mem_rd, mem_reg_write, mem_mem_read, wb_rd, wb_reg_write,
        output fwd_a, fwd_b, fwd_cbz, stall, idex_bubble, flags, blt_taken
    );

endinterface

`default_nettype wire

// File: rtl/ex_hazard_controller_fwd_select.sv
//------------------------------------------------------------------------------
// Module   : fwd_select
// Brief    : Priority compare of one source register against MEM and WB writers.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fwd_select
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int ZERO_REG   = hazard_pkg::ZERO_REG
) (
    input  wire logic [REG_ADDR_W-1:0] i_src,
    input  wire logic [REG_ADDR_W-1:0] i_mem_rd,
    input  wire logic                  i_mem_reg_write,
    input  wire logic                  i_mem_mem_read,
    input  wire logic [REG_ADDR_W-1:0] i_wb_rd,
    input  wire logic                  i_wb_reg_write,
    output fwd_sel_t                   o_sel
);

    localparam logic [REG_ADDR_W-1:0] C_ZERO = REG_ADDR_W'(ZERO_REG);

    logic w_src_valid;
    logic w_mem_hit;
    logic w_wb_hit;

    assign w_src_valid = (i_src != C_ZERO);
    // A load in MEM has no data yet, so it can never be the forwarding source
    assign w_mem_hit   = w_src_valid && i_mem_reg_write && !i_mem_mem_read && (i_mem_rd == i_src);
    assign w_wb_hit    = w_src_valid && i_wb_reg_write && (i_wb_rd == i_src);

    always_comb begin
        o_sel = FWD_RF;
        if (w_mem_hit) begin
            o_sel = FWD_MEM;
        end else if (w_wb_hit) begin
            o_sel = FWD_WB;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ex_hazard_controller.sv
//------------------------------------------------------------------------------
// Module   : ex_hazard_controller
// Brief    : Execute-stage forwarding, load-use/CBZ stall sequencing and NZCV flags.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ex_hazard_controller
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int ZERO_REG   = hazard_pkg::ZERO_REG,
    parameter int FLAG_W     = 4
) (
    input  wire logic             clk,
    input  wire logic             reset,
    ex_hazard_controller_if.slave bus
);

    localparam logic [REG_ADDR_W-1:0] C_ZERO = REG_ADDR_W'(ZERO_REG);

    hz_state_t         r_state_q, w_state_d;
    logic [1:0]        r_cnt_q, w_cnt_d;
    logic [FLAG_W-1:0] r_flags_q, w_flags_d;
    logic [FLAG_W-1:0] w_fwd_flags;
    logic              w_stall;

    fwd_sel_t w_sel_a, w_sel_b, w_sel_cbz;

    logic w_ex_hit_rn, w_ex_hit_rm, w_mem_hit_rm;
    logic w_haz_lu, w_haz_ca, w_haz_cl, w_haz_cm, w_hazard;

    fwd_select #(.REG_ADDR_W(REG_ADDR_W), .ZERO_REG(ZERO_REG)) u_fwd_a (
        .i_src(bus.ex_rn), .i_mem_rd(bus.mem_rd), .i_mem_reg_write(bus.mem_reg_write),
        .i_mem_mem_read(bus.mem_mem_read), .i_wb_rd(bus.wb_rd),
        .i_wb_reg_write(bus.wb_reg_write), .o_sel(w_sel_a)
    );

    fwd_select #(.REG_ADDR_W(REG_ADDR_W), .ZERO_REG(ZERO_REG)) u_fwd_b (
        .i_src(bus.ex_rm), .i_mem_rd(bus.mem_rd), .i_mem_reg_write(bus.mem_reg_write),
        .i_mem_mem_read(bus.mem_mem_read), .i_wb_rd(bus.wb_rd),
        .i_wb_reg_write(bus.wb_reg_write), .o_sel(w_sel_b)
    );

    fwd_select #(.REG_ADDR_W(REG_ADDR_W), .ZERO_REG(ZERO_REG)) u_fwd_cbz (
        .i_src(bus.id_rm), .i_mem_rd(bus.mem_rd), .i_mem_reg_write(bus.mem_reg_write),
        .i_mem_mem_read(bus.mem_mem_read), .i_wb_rd(bus.wb_rd),
        .i_wb_reg_write(bus.wb_reg_write), .o_sel(w_sel_cbz)
    );

    assign w_ex_hit_rn  = bus.ex_reg_write && (bus.ex_rd == bus.id_rn) && (bus.id_rn != C_ZERO);
    assign w_ex_hit_rm  = bus.ex_reg_write && (bus.ex_rd == bus.id_rm) && (bus.id_rm != C_ZERO);
    assign w_mem_hit_rm = bus.mem_reg_write && (bus.mem_rd == bus.id_rm) && (bus.id_rm != C_ZERO);

    assign w_haz_lu = bus.ex_mem_read &&
                      ((bus.id_uses_rn && w_ex_hit_rn) || (bus.id_uses_rm && w_ex_hit_rm));
    assign w_haz_ca = bus.id_is_cbz && w_ex_hit_rm && !bus.ex_mem_read;
    assign w_haz_cl = bus.id_is_cbz && w_ex_hit_rm && bus.ex_mem_read;
    assign w_haz_cm = bus.id_is_cbz && bus.mem_mem_read && w_mem_hit_rm;
    assign w_hazard = w_haz_lu || w_haz_ca || w_haz_cl || w_haz_cm;

    // Reset beats flush, flush beats any hazard or pending hold
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_stall   = 1'b0;
        if (reset || bus.id_flush) begin
            w_state_d = ST_IDLE;
            w_cnt_d   = 2'd0;
        end else begin
            case (r_state_q)
                ST_IDLE: begin
                    w_stall = w_hazard;
                    if (w_haz_cl) begin
                        w_cnt_d   = 2'd1;
                        w_state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    w_stall = 1'b1;
                    w_cnt_d = r_cnt_q - 2'd1;
                    if (r_cnt_q <= 2'd1) begin
                        w_state_d = ST_IDLE;
                    end
                end
                default: begin
                    w_state_d = ST_IDLE;
                    w_cnt_d   = 2'd0;
                end
            endcase
        end
    end

    assign w_flags_d   = bus.ex_set_flags ? bus.alu_flags : r_flags_q;
    assign w_fwd_flags = bus.ex_set_flags ? bus.alu_flags : r_flags_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= ST_IDLE;
            r_cnt_q   <= 2'd0;
            r_flags_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_flags_q <= w_flags_d;
        end
    end

    assign bus.fwd_a       = w_sel_a;
    assign bus.fwd_b       = w_sel_b;
    assign bus.fwd_cbz     = bus.id_is_cbz ? w_sel_cbz : FWD_RF;
    assign bus.stall       = w_stall;
    assign bus.idex_bubble = w_stall;
    assign bus.flags       = r_flags_q;
    assign bus.blt_taken   = !reset && bus.id_is_blt &&
                             (w_fwd_flags[FLAG_N] ^ w_fwd_flags[FLAG_V]);

endmodule

`default_nettype wire

// File: tb/tb_ex_hazard_controller.sv
//------------------------------------------------------------------------------
// Module   : tb_ex_hazard_controller
// Brief    : Directed vector table plus multi-cycle sequences for the hazard controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ex_hazard_controller;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    ex_hazard_controller_if #(.REG_ADDR_W(5), .FLAG_W(4)) hif ();

    ex_hazard_controller #(.REG_ADDR_W(5), .ZERO_REG(31), .FLAG_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] id_rn, id_rm;
        logic       uses_rn, uses_rm, is_cbz;
        logic [4:0] ex_rn, ex_rm, ex_rd;
        logic       ex_rw, ex_mr;
        logic [4:0] mem_rd;
        logic       mem_rw, mem_mr;
        logic [4:0] wb_rd;
        logic       wb_rw;
        logic [1:0] e_a, e_b, e_cbz;
        logic       e_stall;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(int id_rn, int id_rm, int urn, int urm, int cbz,
                                int ex_rn, int ex_rm, int ex_rd, int ex_rw, int ex_mr,
                                int mem_rd, int mem_rw, int mem_mr, int wb_rd, int wb_rw,
                                int e_a, int e_b, int e_cbz, int e_stall);
        vec_t v;
        v.id_rn = 5'(id_rn);   v.id_rm = 5'(id_rm);
        v.uses_rn = 1'(urn);   v.uses_rm = 1'(urm);   v.is_cbz = 1'(cbz);
        v.ex_rn = 5'(ex_rn);   v.ex_rm = 5'(ex_rm);   v.ex_rd = 5'(ex_rd);
        v.ex_rw = 1'(ex_rw);   v.ex_mr = 1'(ex_mr);
        v.mem_rd = 5'(mem_rd); v.mem_rw = 1'(mem_rw); v.mem_mr = 1'(mem_mr);
        v.wb_rd = 5'(wb_rd);   v.wb_rw = 1'(wb_rw);
        v.e_a = 2'(e_a); v.e_b = 2'(e_b); v.e_cbz = 2'(e_cbz); v.e_stall = 1'(e_stall);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hif.id_rn = '0; hif.id_rm = '0; hif.id_uses_rn = 1'b0; hif.id_uses_rm = 1'b0;
        hif.id_is_cbz = 1'b0; hif.id_is_blt = 1'b0; hif.id_flush = 1'b0;
        hif.ex_rn = '0; hif.ex_rm = '0; hif.ex_rd = '0;
        hif.ex_reg_write = 1'b0; hif.ex_mem_read = 1'b0; hif.ex_set_flags = 1'b0;
        hif.alu_flags = '0;
        hif.mem_rd = '0; hif.mem_reg_write = 1'b0; hif.mem_mem_read = 1'b0;
        hif.wb_rd = '0; hif.wb_reg_write = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v);
        clear_inputs();
        hif.id_rn = v.id_rn; hif.id_rm = v.id_rm;
        hif.id_uses_rn = v.uses_rn; hif.id_uses_rm = v.uses_rm; hif.id_is_cbz = v.is_cbz;
        hif.ex_rn = v.ex_rn; hif.ex_rm = v.ex_rm; hif.ex_rd = v.ex_rd;
        hif.ex_reg_write = v.ex_rw; hif.ex_mem_read = v.ex_mr;
        hif.mem_rd = v.mem_rd; hif.mem_reg_write = v.mem_rw; hif.mem_mem_read = v.mem_mr;
        hif.wb_rd = v.wb_rd; hif.wb_reg_write = v.wb_rw;
    endtask

    // CBZ with its Rt produced by a load currently in EX
    task automatic drive_cl(input int rt);
        clear_inputs();
        hif.id_is_cbz = 1'b1; hif.id_rm = 5'(rt); hif.id_uses_rm = 1'b1;
        hif.ex_rd = 5'(rt); hif.ex_reg_write = 1'b1; hif.ex_mem_read = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;

        //            idrn idrm urn urm cbz exrn exrm exrd erw emr memrd mrw mmr wbrd wrw  a  b  cbz st
        vecs[0]  = mk( 0,  0,  0,  0,  0,  3,   0,   0,  0,  0,   3,   1,  0,   3,  1,  1, 0, 0, 0);
        vecs[1]  = mk( 0,  0,  0,  0,  0,  3,   0,   0,  0,  0,   3,   0,  0,   3,  1,  2, 0, 0, 0);
        vecs[2]  = mk( 0,  0,  0,  0,  0, 31,  31,   0,  0,  0,  31,   1,  0,  31,  1,  0, 0, 0, 0);
        vecs[3]  = mk( 0,  0,  0,  0,  0,  0,   4,   0,  0,  0,   4,   1,  1,   4,  1,  0, 2, 0, 0);
        vecs[4]  = mk( 0,  0,  0,  0,  0,  0,   4,   0,  0,  0,   4,   1,  1,   4,  0,  0, 0, 0, 0);
        vecs[5]  = mk( 0,  0,  0,  0,  0,  6,   9,   0,  0,  0,   9,   1,  0,   6,  1,  2, 1, 0, 0);
        vecs[6]  = mk( 0,  5,  0,  1,  0,  0,   0,   5,  1,  1,   0,   0,  0,   0,  0,  0, 0, 0, 1);
        vecs[7]  = mk( 0,  5,  0,  0,  0,  0,   0,   5,  1,  1,   0,   0,  0,   0,  0,  0, 0, 0, 0);
        vecs[8]  = mk(31,  0,  1,  0,  0,  0,   0,  31,  1,  1,   0,   0,  0,   0,  0,  0, 0, 0, 0);
        vecs[9]  = mk( 0,  8,  0,  1,  1,  0,   0,   8,  1,  0,   0,   0,  0,   0,  0,  0, 0, 0, 1);
        vecs[10] = mk( 0,  2,  0,  1,  1,  0,   0,   0,  0,  0,   2,   1,  1,   0,  0,  0, 0, 0, 1);
        vecs[11] = mk( 0, 10,  0,  1,  1,  0,   0,   0,  0,  0,  10,   1,  0,   0,  0,  0, 0, 1, 0);
        vecs[12] = mk( 0, 10,  0,  1,  1,  0,   0,   0,  0,  0,   0,   0,  0,  10,  1,  0, 0, 2, 0);
        vecs[13] = mk( 5,  0,  1,  0,  0,  0,   0,   5,  1,  0,   0,   0,  0,   0,  0,  0, 0, 0, 0);
        vecs[14] = mk( 0,  8,  0,  1,  1,  0,   0,   8,  0,  0,   0,   0,  0,   0,  0,  0, 0, 0, 0);
        vecs[15] = mk( 0, 10,  0,  1,  0,  0,   0,   0,  0,  0,  10,   1,  0,   0,  0,  0, 0, 0, 0);
        vecs[16] = mk( 5,  0,  1,  0,  0,  0,   0,   5,  1,  1,   0,   0,  0,   0,  0,  0, 0, 0, 1);

        // Reset overrides hazards and flag writes
        reset = 1'b1;
        clear_inputs();
        cyc();
        cyc();
        apply_vec(vecs[16]);
        hif.id_is_blt = 1'b1; hif.ex_set_flags = 1'b1; hif.alu_flags = 4'b0010;
        #3;
        chk("rst_stall", 32'(hif.stall), 32'd0);
        chk("rst_bubble", 32'(hif.idex_bubble), 32'd0);
        chk("rst_blt", 32'(hif.blt_taken), 32'd0);
        cyc();
        #3;
        chk("rst_flags", 32'(hif.flags), 32'd0);
        cyc();
        reset = 1'b0;
        clear_inputs();

        for (int i = 0; i < 17; i++) begin
            cyc();
            apply_vec(vecs[i]);
            #3;
            chk($sformatf("v%0d_fwd_a", i), 32'(hif.fwd_a), 32'(vecs[i].e_a));
            chk($sformatf("v%0d_fwd_b", i), 32'(hif.fwd_b), 32'(vecs[i].e_b));
            chk($sformatf("v%0d_fwd_cbz", i), 32'(hif.fwd_cbz), 32'(vecs[i].e_cbz));
            chk($sformatf("v%0d_stall", i), 32'(hif.stall), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d_bubble", i), 32'(hif.idex_bubble), 32'(vecs[i].e_stall));
        end

        // Load-use: one bubble, then the load reaches WB and feeds operand A
        cyc(); clear_inputs();
        hif.id_rn = 5'd5; hif.id_uses_rn = 1'b1;
        hif.ex_rd = 5'd5; hif.ex_reg_write = 1'b1; hif.ex_mem_read = 1'b1;
        #3; chk("lu_stall0", 32'(hif.stall), 32'd1);
        cyc(); clear_inputs();
        hif.id_rn = 5'd5; hif.id_uses_rn = 1'b1;
        hif.mem_rd = 5'd5; hif.mem_reg_write = 1'b1; hif.mem_mem_read = 1'b1;
        #3; chk("lu_stall1", 32'(hif.stall), 32'd0);
        cyc(); clear_inputs();
        hif.ex_rn = 5'd5; hif.wb_rd = 5'd5; hif.wb_reg_write = 1'b1;
        #3; chk("lu_fwd_a", 32'(hif.fwd_a), 32'd2);

        // CBZ after LDUR: two stall cycles, then Rt forwarded from WB
        cyc(); drive_cl(7);
        #3; chk("cl_stall0", 32'(hif.stall), 32'd1);
        cyc(); clear_inputs();
        hif.id_is_cbz = 1'b1; hif.id_rm = 5'd7; hif.id_uses_rm = 1'b1;
        hif.mem_rd = 5'd7; hif.mem_reg_write = 1'b1; hif.mem_mem_read = 1'b1;
        #3; chk("cl_stall1", 32'(hif.stall), 32'd1);
        cyc(); clear_inputs();
        hif.id_is_cbz = 1'b1; hif.id_rm = 5'd7; hif.id_uses_rm = 1'b1;
        hif.wb_rd = 5'd7; hif.wb_reg_write = 1'b1;
        #3; chk("cl_stall2", 32'(hif.stall), 32'd0);
        chk("cl_fwd_cbz", 32'(hif.fwd_cbz), 32'd2);

        // Second cycle of a CL stall holds even with hazard-free inputs
        cyc(); drive_cl(12);
        #3; chk("hold_stall0", 32'(hif.stall), 32'd1);
        cyc(); clear_inputs();
        #3; chk("hold_stall1", 32'(hif.stall), 32'd1);
        chk("hold_bubble1", 32'(hif.idex_bubble), 32'd1);
        cyc();
        #3; chk("hold_stall2", 32'(hif.stall), 32'd0);

        // Flush cancels a hold in progress and overrides a fresh hazard
        cyc(); drive_cl(9);
        #3; chk("fl_stall0", 32'(hif.stall), 32'd1);
        cyc(); clear_inputs(); hif.id_flush = 1'b1;
        #3; chk("fl_stall1", 32'(hif.stall), 32'd0);
        chk("fl_bubble1", 32'(hif.idex_bubble), 32'd0);
        cyc(); clear_inputs();
        #3; chk("fl_idle", 32'(hif.stall), 32'd0);
        cyc(); apply_vec(vecs[16]); hif.id_flush = 1'b1;
        #3; chk("fl_lu", 32'(hif.stall), 32'd0);

        // Flag register load and hold; B.LT from the registered flags
        cyc(); clear_inputs(); hif.ex_set_flags = 1'b1; hif.alu_flags = 4'b0001;
        cyc(); clear_inputs(); hif.alu_flags = 4'b1111;
        #3; chk("flags_load", 32'(hif.flags), 32'h1);
        cyc(); hif.id_is_blt = 1'b1;
        #3; chk("flags_hold", 32'(hif.flags), 32'h1);
        chk("blt_reg", 32'(hif.blt_taken), 32'd1);
        cyc(); hif.id_is_blt = 1'b0;
        #3; chk("blt_gated", 32'(hif.blt_taken), 32'd0);

        // Reset during HOLD returns to IDLE and clears flags
        cyc(); drive_cl(14);
        #3; chk("rh_stall0", 32'(hif.stall), 32'd1);
        cyc(); clear_inputs(); reset = 1'b1;
        #3; chk("rh_stall1", 32'(hif.stall), 32'd0);
        cyc(); reset = 1'b0;
        #3; chk("rh_flags", 32'(hif.flags), 32'd0);
        chk("rh_idle", 32'(hif.stall), 32'd0);

        // B.LT resolution with flags forwarded from a flag-setting EX instruction
        cyc(); clear_inputs();
        hif.id_is_blt = 1'b1; hif.ex_set_flags = 1'b1; hif.alu_flags = 4'b0010;
        #3; chk("blt_stale", 32'(hif.flags), 32'd0);
        chk("blt_fwd_v", 32'(hif.blt_taken), 32'd1);
        cyc(); hif.alu_flags = 4'b0011;
        #3; chk("blt_fwd_nv", 32'(hif.blt_taken), 32'd0);
        cyc(); hif.ex_set_flags = 1'b0; hif.alu_flags = 4'b0000;
        #3; chk("blt_flags3", 32'(hif.flags), 32'h3);
        chk("blt_reg_nv", 32'(hif.blt_taken), 32'd0);
        cyc(); hif.ex_set_flags = 1'b1; hif.alu_flags = 4'b0001;
        #3; chk("blt_override", 32'(hif.blt_taken), 32'd1);

        cyc(); clear_inputs();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
